// File: rtl/tile_rom_arbiter.sv
// tile_rom_arbiter: shares one tile ROM between the renderer (priority) and game-logic queries,
// routing each returned word to its owner through a latency-matched tag pipeline.
module tile_rom_arbiter #(
  parameter int IDX_W    = 8,
  parameter int ROW_W    = 4,
  parameter int COL_W    = 4,
  parameter int PIX_W    = 8,
  parameter int TYPE_W   = 2,
  parameter int ROM_LAT  = 2,
  parameter int MAX_WAIT = 16
) (
  input  logic                         vclock,
  input  logic                         rst,
  input  logic                         vid_valid,
  input  logic [IDX_W-1:0]             vid_index,
  input  logic [ROW_W-1:0]             vid_row,
  input  logic [COL_W-1:0]             vid_col,
  output logic                         vid_rvalid,
  output logic [PIX_W-1:0]             vid_pixel,
  output logic                         vid_transparent,
  output logic                         vid_drop,
  input  logic                         game_req,
  input  logic [IDX_W-1:0]             game_index,
  input  logic [ROW_W-1:0]             game_row,
  input  logic [COL_W-1:0]             game_col,
  output logic                         game_ack,
  output logic                         game_rvalid,
  output logic [TYPE_W-1:0]            game_type,
  output logic                         game_transparent,
  output logic [IDX_W+ROW_W+COL_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]             rom_pixel,
  input  logic [TYPE_W-1:0]            rom_type,
  input  logic                         rom_transparent
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0]    wait_cnt;
  logic [ROM_LAT:0] tag_v, tag_g;
  logic             frc, grant_vid, grant_game;
  always_comb begin
    frc        = wait_cnt == CW'(MAX_WAIT);
    grant_vid  = vid_valid & ~frc;
    grant_game = game_req & (~vid_valid | frc);
    game_ack   = rst & grant_game;
    vid_drop   = rst & vid_valid & frc;
  end
  assign vid_rvalid  = tag_v[ROM_LAT] & ~tag_g[ROM_LAT];
  assign game_rvalid = tag_v[ROM_LAT] & tag_g[ROM_LAT];
  always_ff @(posedge vclock or negedge rst)
    if (!rst) begin
      rom_addr         <= '0;
      tag_v            <= '0;
      tag_g            <= '0;
      wait_cnt         <= '0;
      vid_pixel        <= '0;
      vid_transparent  <= 1'b0;
      game_type        <= '0;
      game_transparent <= 1'b0;
    end else begin
      if (grant_game) rom_addr <= {game_index, game_row, game_col};
      else if (grant_vid) rom_addr <= {vid_index, vid_row, vid_col};
      tag_v    <= {tag_v[ROM_LAT-1:0], grant_vid | grant_game};
      tag_g    <= {tag_g[ROM_LAT-1:0], grant_game};
      wait_cnt <= (!game_req || grant_game) ? '0 : (frc ? wait_cnt : wait_cnt + 1'b1);
      // douta for a tag is on the bus the cycle before the tag reaches the last stage
      if (tag_v[ROM_LAT-1] && !tag_g[ROM_LAT-1]) begin
        vid_pixel       <= rom_pixel;
        vid_transparent <= rom_transparent;
      end
      if (tag_v[ROM_LAT-1] && tag_g[ROM_LAT-1]) begin
        game_type        <= rom_type;
        game_transparent <= rom_transparent;
      end
    end
endmodule

// File: tb/tb_tile_rom_arbiter.sv
// tb_tile_rom_arbiter: randomized and directed checks against a queue-based reference model.
module tb_tile_rom_arbiter;
  localparam int LAT = 3;
  localparam int MW  = 16;
  logic        vclock = 0, rst = 0;
  logic        vid_valid = 0, game_req = 0;
  logic [7:0]  vid_index = 0, game_index = 0;
  logic [3:0]  vid_row = 0, vid_col = 0, game_row = 0, game_col = 0;
  logic        vid_rvalid, vid_transparent, vid_drop, game_ack, game_rvalid, game_transparent;
  logic [7:0]  vid_pixel, rom_pixel;
  logic [1:0]  game_type, rom_type;
  logic        rom_transparent;
  logic [15:0] rom_addr, rom_q;
  tile_rom_arbiter dut (
    .vclock(vclock), .rst(rst),
    .vid_valid(vid_valid), .vid_index(vid_index), .vid_row(vid_row), .vid_col(vid_col),
    .vid_rvalid(vid_rvalid), .vid_pixel(vid_pixel), .vid_transparent(vid_transparent), .vid_drop(vid_drop),
    .game_req(game_req), .game_index(game_index), .game_row(game_row), .game_col(game_col),
    .game_ack(game_ack), .game_rvalid(game_rvalid), .game_type(game_type), .game_transparent(game_transparent),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel), .rom_type(rom_type), .rom_transparent(rom_transparent)
  );
  always #5 vclock = ~vclock;
  function automatic logic [10:0] romf(input logic [15:0] a);
    return {^a, a[1:0] ^ a[9:8], a[7:0] ^ a[15:8] ^ 8'h5a};
  endfunction
  always @(posedge vclock) rom_q <= rom_addr;
  assign {rom_transparent, rom_type, rom_pixel} = romf(rom_q);
  typedef struct { bit game; logic [15:0] addr; int due; } ret_t;
  ret_t        sb[$];
  int          tests = 0, fails = 0, cyc = 0, mwait = 0;
  logic [15:0] m_addr = 0;
  logic [7:0]  m_vpix = 0;
  logic        m_vtr = 0, m_gtr = 0, ack_seen;
  logic [1:0]  m_gtype = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input bit vv, input logic [15:0] va, input bit gr, input logic [15:0] ga);
    bit frc, eack, edrop, ev, eg;
    logic [10:0] w;
    vid_valid = vv; {vid_index, vid_row, vid_col} = va;
    game_req = gr; {game_index, game_row, game_col} = ga;
    @(negedge vclock);
    frc   = (mwait == MW);
    eack  = gr && (!vv || frc);
    edrop = vv && frc;
    chk("game_ack", game_ack, eack);
    chk("vid_drop", vid_drop, edrop);
    chk("rom_addr", rom_addr, m_addr);
    ev = 0; eg = 0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      w = romf(sb[0].addr);
      if (sb[0].game) begin eg = 1; m_gtype = w[9:8]; m_gtr = w[10]; end
      else begin ev = 1; m_vpix = w[7:0]; m_vtr = w[10]; end
      void'(sb.pop_front());
    end
    chk("vid_rvalid", vid_rvalid, ev);
    chk("game_rvalid", game_rvalid, eg);
    chk("vid_pixel", vid_pixel, m_vpix);
    chk("vid_transparent", vid_transparent, m_vtr);
    chk("game_type", game_type, m_gtype);
    chk("game_transparent", game_transparent, m_gtr);
    ack_seen = game_ack;
    if (eack) begin sb.push_back('{1, ga, cyc + LAT}); m_addr = ga; end
    else if (vv && !frc) begin sb.push_back('{0, va, cyc + LAT}); m_addr = va; end
    mwait = (!gr || eack) ? 0 : (mwait < MW ? mwait + 1 : MW);
    @(posedge vclock); #1;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 16'h0);
  endtask
  task automatic do_reset();
    vid_valid = 0; game_req = 0;
    rst = 0;
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_outs", {vid_rvalid, vid_pixel, vid_transparent, vid_drop, game_ack, game_rvalid, game_type, game_transparent}, 0);
    sb.delete(); mwait = 0; m_addr = 0; m_vpix = 0; m_vtr = 0; m_gtype = 0; m_gtr = 0;
    @(posedge vclock); #1;
    rst = 1;
    cyc++;
  endtask
  initial begin
    int got;
    logic [15:0] ga;
    repeat (2) @(posedge vclock);
    #1;
    do_reset();
    step(1, 16'h1235, 0, 16'h0);
    idle(4);
    step(0, 16'h0, 1, 16'h4000);
    idle(4);
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 0, 16'h0);
    got = -1;
    for (int i = 0; i < 40 && got < 0; i++) begin
      step(1, 16'($urandom), 1, 16'h4321);
      if (ack_seen) got = i;
    end
    chk("force_latency", got, MW);
    for (int i = 0; i < 6; i++) step(1, 16'($urandom), 0, 16'h0);
    idle(4);
    for (int i = 0; i < 20; i++) step(i % 2 == 0, 16'($urandom), i % 2 == 1, 16'($urandom));
    idle(4);
    step(1, 16'hab12, 0, 16'h0);
    step(0, 16'h0, 1, 16'h77c3);
    do_reset();
    idle(2);
    step(0, 16'h0, 1, 16'h1f0e);
    idle(4);
    for (int i = 0; i < 10; i++) step(1, 16'($urandom), 1, 16'h2222);
    step(1, 16'($urandom), 0, 16'h0);
    got = -1;
    for (int i = 0; i < 40 && got < 0; i++) begin
      step(1, 16'($urandom), 1, 16'h3333);
      if (ack_seen) got = i;
    end
    chk("restart_latency", got, MW);
    idle(4);
    ga = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      bit gr;
      gr = game_req && !ack_seen ? 1'b1 : ($urandom_range(0, 2) == 0);
      if (!(game_req && !ack_seen)) ga = 16'($urandom);
      step($urandom_range(0, 7) != 0, 16'($urandom), gr, ga);
    end
    idle(6);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
